serial_addsub5: RTL and testbench
=================================

# serial_addsub5

Bit-serial add/subtract unit for the 5-bit datapath. It accepts two operands on a start pulse and computes `a+b` or `a-b` one bit per clock, LSB first, using a single full-adder cell. Subtraction is two's complement: `b` is inverted and carry-in is 1. The block sits beside the combinational ALU as the low-area arithmetic path and reports the result with carry, borrow and zero flags.

## Interface
- `WIDTH`, default 5: operand and result width in bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high. Sampled only on the rising edge of `clk`.
- `start` input 1: request a new operation. Sampled on the rising edge.
- `op` input 1: operation select, sampled with `start`. 0 = add, 1 = subtract.
- `a` input WIDTH: first operand, unsigned. Sampled with `start`.
- `b` input WIDTH: second operand, unsigned. Sampled with `start`.
- `busy` output 1: high while the operation is in progress.
- `done` output 1: one-cycle pulse; marks `result` and the flags as valid.
- `result` output WIDTH: sum or difference, modulo 2^WIDTH.
- `cout` output 1: carry-out of the add. Forced to 0 after a subtract.
- `borrow` output 1: high after a subtract when `a < b`. Forced to 0 after an add.
- `zero` output 1: high when `result == 0`.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE or DONE with `start=1`:**
  - latch `a` into `ra`;
  - latch `b` into `rb` if `op=0`, or `~b` if `op=1`;
  - set the carry register `c = op` and latch `op`;
  - clear the bit counter and go to SHIFT.
- **IDLE with `start=0`:** stay in IDLE.
- **DONE with `start=0`:** go to IDLE.
- **SHIFT, each cycle:**
  - `s = ra[0] ^ rb[0] ^ c`;
  - `c <= maj(ra[0], rb[0], c)`;
  - shift `ra` and `rb` right by 1;
  - shift the result register right, inserting `s` at the MSB;
  - increment the counter.
- **SHIFT exit:** on the edge that processes bit WIDTH-1, go to DONE and register the flags:
  - `cout = c_final & ~op`;
  - `borrow = ~c_final & op`;
  - `zero = (final result == 0)`.
- `start` while in SHIFT is ignored. No queuing; operands are not re-sampled.
- `result` and the flags hold their values from the end of one operation until the end of the next one. They do not change during SHIFT.
- Arithmetic is unsigned modulo 2^WIDTH. No signed overflow flag is produced.

## Timing
- Reset values: `busy=0`, `done=0`, `result=0`, `cout=0`, `borrow=0`, `zero=0`; FSM in IDLE; counter 0.
- `start` is sampled at edge E0. `busy` is high from E0 to E(WIDTH), i.e. WIDTH cycles.
- `done=1` and `busy=0` after edge E(WIDTH); `done` is high for exactly one cycle.
- Latency from the start edge to `done` is WIDTH cycles.
- Back-to-back operation: `start` asserted during the `done` cycle is accepted. Next-operation `busy` goes high the following cycle, so there are 0 idle cycles between operations.
- Reset asserted mid-operation aborts it:
  - all outputs return to their reset values on that edge;
  - no `done` pulse is produced.
- Reset has priority over `start` on the same edge.

## Test plan
- **Add, no carry:** reset, `op=0`, `a=13`, `b=9` → after 5 cycles `done=1`, `result=22`, `cout=0`, `zero=0`; `busy` high for exactly 5 cycles.
- **Add with wrap:** `op=0`, `a=31`, `b=1` → `result=0`, `cout=1`, `zero=1`, `borrow=0`.
- **Subtract, negative:** `op=1`, `a=9`, `b=13` → `result=28`, `borrow=1`, `cout=0`, `zero=0`.
  - Subtract, equal: `op=1`, `a=13`, `b=13` → `result=0`, `borrow=0`, `zero=1`.
- **Start ignored while busy:** `start` with `a=5`, `b=3`, `op=0`; re-pulse `start` with `a=1`, `b=1` at cycle 2 → single `done` at cycle 5 with `result=8`.
  - Back-to-back: `start` held during the `done` cycle with `a=2`, `b=2` → second `done` exactly 5 cycles later, `result=4`.
- **Reset mid-operation:** `start` `a=31`, `b=31`, `op=0`; assert `reset` at cycle 3 → all outputs 0 the next cycle, no `done` pulse.
  - After reset: a new start `a=1`, `b=2` → `result=3` after 5 cycles.

Source files
------------

// File: rtl/serial_addsub5.sv
// Bit-serial add/subtract unit: one full-adder cell, LSB first, WIDTH cycles per operation.
// Subtraction uses two's complement (inverted b, carry-in 1); flags are registered at completion.
module serial_addsub5 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             borrow,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] acc;
  logic             c;
  logic             op_q;
  logic [CW-1:0]    cnt;

  logic             load;
  logic             last;
  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] final_res;

  // Full-adder cell and the accumulator value after inserting this cycle's sum bit
  always_comb begin
    sum_bit    = ra[0] ^ rb[0] ^ c;
    carry_next = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
    last       = (cnt == CW'(WIDTH - 1));
    shifted    = {sum_bit, acc};
    final_res  = shifted[WIDTH:1];
  end

  // Next-state and operand-load decode
  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
      SHIFT: begin
        if (last) begin
          next_state = DONE;
        end else begin
          next_state = SHIFT;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          next_state = SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; result/flags only move on the final bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      ra     <= {WIDTH{1'b0}};
      rb     <= {WIDTH{1'b0}};
      acc    <= {WIDTH{1'b0}};
      c      <= 1'b0;
      op_q   <= 1'b0;
      cnt    <= {CW{1'b0}};
      result <= {WIDTH{1'b0}};
      cout   <= 1'b0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == SHIFT);
      done  <= (next_state == DONE);
      if (load) begin
        ra   <= a;
        rb   <= op ? ~b : b;
        c    <= op;
        op_q <= op;
        cnt  <= {CW{1'b0}};
      end else if (state == SHIFT) begin
        ra  <= ra >> 1;
        rb  <= rb >> 1;
        c   <= carry_next;
        acc <= final_res;
        cnt <= cnt + CW'(1);
        if (last) begin
          result <= final_res;
          cout   <= carry_next & ~op_q;
          borrow <= ~carry_next & op_q;
          zero   <= (final_res == {WIDTH{1'b0}});
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub5.sv
// Self-checking bench for serial_addsub5: directed table, random ops against an arithmetic model,
// and hand-written sequences for start-while-busy, back-to-back and reset abort.
module tb_serial_addsub5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       op;
  logic [4:0] a;
  logic [4:0] b;
  logic       busy;
  logic       done;
  logic [4:0] result;
  logic       cout;
  logic       borrow;
  logic       zero;

  int compared   = 0;
  int mismatched = 0;

  serial_addsub5 #(.WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .borrow(borrow), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a; int b; int op;
    int res; int cout; int borrow; int zero;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Starts an operation from a point #1 after an edge; returns cycles to done and busy count.
  task automatic run_op(input int ta, input int tb_, input int top, output int lat, output int busy_cycles);
    a = 5'(ta); b = 5'(tb_); op = top[0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cycles = 0;
    while (lat < 20) begin
      if (busy) busy_cycles++;
      if (done) break;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    vec_t vecs[6];
    int lat, bc;
    int exp_res, exp_c, exp_bw, exp_z;
    int done_cyc[$];
    int done_res[$];
    int busy_at6;
    int n_done;

    vecs[0] = '{a:13, b:9,  op:0, res:22, cout:0, borrow:0, zero:0};
    vecs[1] = '{a:31, b:1,  op:0, res:0,  cout:1, borrow:0, zero:1};
    vecs[2] = '{a:9,  b:13, op:1, res:28, cout:0, borrow:1, zero:0};
    vecs[3] = '{a:13, b:13, op:1, res:0,  cout:0, borrow:0, zero:1};
    vecs[4] = '{a:20, b:3,  op:1, res:17, cout:0, borrow:0, zero:0};
    vecs[5] = '{a:16, b:17, op:0, res:1,  cout:1, borrow:0, zero:0};

    reset = 1'b1; start = 1'b0; op = 1'b0; a = 5'd0; b = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset flags", {cout, borrow, zero}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat, bc);
      check($sformatf("vec%0d latency", i), lat, 5);
      check($sformatf("vec%0d busy cycles", i), bc, 5);
      check($sformatf("vec%0d result", i), result, vecs[i].res);
      check($sformatf("vec%0d cout", i), cout, vecs[i].cout);
      check($sformatf("vec%0d borrow", i), borrow, vecs[i].borrow);
      check($sformatf("vec%0d zero", i), zero, vecs[i].zero);
      @(posedge clk); #1;
      check($sformatf("vec%0d done width", i), done, 0);
      check($sformatf("vec%0d result hold", i), result, vecs[i].res);
    end

    for (int i = 0; i < 40; i++) begin
      int ra_v, rb_v, rop;
      ra_v = int'($urandom_range(31, 0));
      rb_v = int'($urandom_range(31, 0));
      rop  = int'($urandom_range(1, 0));
      if (rop == 1) begin
        exp_res = (ra_v - rb_v + 32) % 32;
        exp_c   = 0;
        exp_bw  = (ra_v < rb_v) ? 1 : 0;
      end else begin
        exp_res = (ra_v + rb_v) % 32;
        exp_c   = (ra_v + rb_v >= 32) ? 1 : 0;
        exp_bw  = 0;
      end
      exp_z = (exp_res == 0) ? 1 : 0;
      run_op(ra_v, rb_v, rop, lat, bc);
      check($sformatf("rnd%0d latency", i), lat, 5);
      check($sformatf("rnd%0d result", i), result, exp_res);
      check($sformatf("rnd%0d flags", i), {cout, borrow, zero}, (exp_c << 2) | (exp_bw << 1) | exp_z);
    end

    // Start ignored while busy, then back-to-back start during the done cycle
    a = 5'd5; b = 5'd3; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_at6 = -1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (done) begin
        done_cyc.push_back(k);
        done_res.push_back(int'(result));
      end
      if (k == 6) busy_at6 = busy;
      if (k == 1) begin
        start = 1'b1; a = 5'd1; b = 5'd1;
      end else if (done && k < 8) begin
        start = 1'b1; a = 5'd2; b = 5'd2;
      end else begin
        start = 1'b0;
      end
    end
    check("busy-ignore done count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) begin
      check("busy-ignore done cycle", done_cyc[0], 5);
      check("busy-ignore result", done_res[0], 8);
      check("b2b done cycle", done_cyc[1], 11);
      check("b2b result", done_res[1], 4);
    end
    check("b2b busy next cycle", busy_at6, 1);

    // Reset mid-operation aborts with no done pulse
    a = 5'd31; b = 5'd31; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 0);
    check("abort flags", {cout, borrow, zero}, 0);
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      if (done || busy) n_done++;
      @(posedge clk); #1;
    end
    check("abort no done", n_done, 0);

    run_op(1, 2, 0, lat, bc);
    check("post-reset latency", lat, 5);
    check("post-reset result", result, 3);
    check("post-reset flags", {cout, borrow, zero}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
